fetch_controller: RTL

//  Sequences the InstructionMemory block: generates the fetch PC, tracks the single
//  in-flight read (1-cycle registered latency) and buffers returned words. Delivers
//  {pc, instruction} to decode over a valid/ready handshake.

---
 rtl/fetch_controller_pkg.sv | 13 +
 rtl/fetch_controller_buffer.sv | 63 ++++++
 rtl/fetch_controller.sv | 104 ++++++++++
 3 files changed

// File: rtl/fetch_controller_pkg.sv
// Shared fetch-stage definitions: default widths, halt encoding and the fetch FSM state type.
package fetch_controller_pkg;
   localparam int unsigned FC_PC_W    = 8;
   localparam int unsigned FC_INSTR_W = 32;
   localparam int unsigned FC_PC_STEP = 4;
   localparam logic [31:0] FC_HALT_INSTR = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_RUN  = 2'd1,
      FS_HALT = 2'd2
   } fetch_state_e;
endpackage

// File: rtl/fetch_controller_buffer.sv
// Two-entry {pc, instr} FIFO between instruction memory and decode; flush wins over push/pop.
module fetch_controller_buffer #(
   parameter int unsigned PC_W    = 8,
   parameter int unsigned INSTR_W = 32
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               push_i,
   input  logic [PC_W-1:0]    push_pc_i,
   input  logic [INSTR_W-1:0] push_instr_i,
   input  logic               pop_i,
   input  logic               flush_i,
   output logic [PC_W-1:0]    head_pc_o,
   output logic [INSTR_W-1:0] head_instr_o,
   output logic [1:0]         count_o,
   output logic               empty_o
);
   logic [PC_W-1:0]    pc_q    [2];
   logic [INSTR_W-1:0] instr_q [2];
   logic               wr_ptr_q, wr_ptr_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic [1:0]         count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_i) wr_ptr_d = ~wr_ptr_q;
         if (pop_i)  rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q[0]    <= '0;
         pc_q[1]    <= '0;
         instr_q[0] <= '0;
         instr_q[1] <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         if (push_i && !flush_i) begin
            pc_q[wr_ptr_q]    <= push_pc_i;
            instr_q[wr_ptr_q] <= push_instr_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_pc_o    = pc_q[rd_ptr_q];
   assign head_instr_o = instr_q[rd_ptr_q];
   assign count_o      = count_q;
   assign empty_o      = (count_q == 2'd0);
endmodule

// File: rtl/fetch_controller.sv
// Fetch stage: PC generation, single in-flight read tracking, redirect/halt handling,
// and a two-entry return buffer presented to decode over valid/ready.
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter int unsigned        PC_W       = FC_PC_W,
   parameter int unsigned        INSTR_W    = FC_INSTR_W,
   parameter logic [PC_W-1:0]    RESET_PC   = '0,
   parameter logic [PC_W-1:0]    PC_STEP    = PC_W'(FC_PC_STEP),
   parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(FC_HALT_INSTR)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   output logic [PC_W-1:0]    imem_pc_o,
   input  logic [INSTR_W-1:0] imem_instr_i,
   input  logic               redirect_valid_i,
   input  logic [PC_W-1:0]    redirect_pc_i,
   output logic               if_valid_o,
   input  logic               if_ready_i,
   output logic [INSTR_W-1:0] if_instr_o,
   output logic [PC_W-1:0]    if_pc_o,
   output logic               halted_o
);
   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            inflight_q, inflight_d;
   logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

   logic       xfer, halt_xfer, flush, issue, push, empty;
   logic [1:0] count, occ;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= FS_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FS_IDLE: if (start_i) state_d = FS_RUN;
         FS_RUN:  if (!redirect_valid_i && halt_xfer) state_d = FS_HALT;
         FS_HALT: if (redirect_valid_i) state_d = FS_RUN;
         default: state_d = FS_IDLE;
      endcase
   end

   // A read may issue while occupancy stays <= 2 after this edge; redirect and halt suppress it.
   always_comb begin
      xfer      = !empty && if_ready_i;
      halt_xfer = (state_q == FS_RUN) && xfer && (if_instr_o == HALT_INSTR);
      flush     = ((state_q != FS_IDLE) && redirect_valid_i) || halt_xfer;
      occ       = count + {1'b0, inflight_q};
      issue     = (state_q == FS_RUN) && !redirect_valid_i && !halt_xfer &&
                  ((occ < 2'd2) || ((occ == 2'd2) && xfer));
      push      = inflight_q && !flush;
      halted_o  = (state_q == FS_HALT);
   end

   always_comb begin
      pc_d = pc_q;
      if (state_q == FS_IDLE) begin
         if (start_i) pc_d = RESET_PC;
      end else if (redirect_valid_i) begin
         pc_d = redirect_pc_i;
      end else if (issue) begin
         pc_d = pc_q + PC_STEP;
      end
      inflight_d    = issue;
      inflight_pc_d = issue ? pc_q : inflight_pc_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_controller_buffer #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) u_buffer (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .push_i       (push),
      .push_pc_i    (inflight_pc_q),
      .push_instr_i (imem_instr_i),
      .pop_i        (xfer),
      .flush_i      (flush),
      .head_pc_o    (if_pc_o),
      .head_instr_o (if_instr_o),
      .count_o      (count),
      .empty_o      (empty)
   );

   assign imem_pc_o  = pc_q;
   assign if_valid_o = !empty;
endmodule
